// File: rtl/dog_pkg.sv
// Shared constants for the difference-of-Gaussians stage: frame geometry defaults,
// result/coordinate widths and the border radius used for edge classification.
package dog_pkg;

    localparam int unsigned IMG_W_DEF = 400;
    localparam int unsigned IMG_H_DEF = 300;
    localparam int unsigned DOG_W     = 9;
    localparam int unsigned COORD_W   = 9;
    localparam int unsigned BORDER_R  = 2;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [DOG_W-1:0]   dog_t;

    // True when (x,y) lies within BORDER_R pixels of any edge of a w x h frame.
    function automatic logic is_border(input coord_t x, input coord_t y,
                                       input int unsigned w, input int unsigned h);
        return (x < coord_t'(BORDER_R)) || (x > coord_t'(w - 1 - BORDER_R)) ||
               (y < coord_t'(BORDER_R)) || (y > coord_t'(h - 1 - BORDER_R));
    endfunction

endpackage

// File: rtl/dog_align_fifo.sv
// Synchronous alignment FIFO holding early a-samples until the matching b-sample
// arrives. DEPTH must be a power of two so the pointers wrap naturally.
module dog_align_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic                     rd_en_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en_i) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_en_i) rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({wr_en_i, rd_en_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked solely by the pointers.
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/dog_stage.sv
// DoG stage: aligns the early a-stream to the late b-stream and emits b - a with
// frame coordinates. Define DOG_BORDER_MASK_EN to force dout to 0 on border pixels.
module dog_stage
    import dog_pkg::*;
#(
    parameter int unsigned IMG_W = IMG_W_DEF,
    parameter int unsigned IMG_H = IMG_H_DEF,
    parameter int unsigned DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_en,
    input  logic [7:0]         a_din,
    input  logic               a_valid,
    input  logic [7:0]         b_din,
    input  logic               b_valid,
    output logic [DOG_W-1:0]   dout,
    output logic               dout_valid,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               border,
    output logic               frame_end,
    output logic               ovf,
    output logic               unf
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          fifo_full, fifo_empty, fifo_wr, fifo_rd;
    logic [7:0]    fifo_rdata, a_sel;
    logic [CW-1:0] fifo_count;
    logic          push, pop, bypass, last_px, border_now;
    dog_t          diff;

    dog_t   dout_q, dout_d;
    logic   dout_valid_q, dout_valid_d;
    coord_t x_q, x_d, y_q, y_d, cx_q, cx_d, cy_q, cy_d;
    logic   border_q, border_d, frame_end_q, frame_end_d;
    logic   ovf_q, ovf_d, unf_q, unf_d;

    // An empty FIFO with a and b arriving together pairs them directly without storage.
    assign push    = clk_en & a_valid;
    assign bypass  = push & b_valid & fifo_empty;
    assign pop     = clk_en & b_valid & (~fifo_empty | push);
    assign fifo_rd = pop & ~fifo_empty;
    assign fifo_wr = push & ~bypass & (~fifo_full | fifo_rd);
    assign a_sel   = bypass ? a_din : fifo_rdata;
    assign diff    = {1'b0, b_din} - {1'b0, a_sel};

    assign last_px    = (cx_q == coord_t'(IMG_W - 1)) && (cy_q == coord_t'(IMG_H - 1));
    assign border_now = is_border(cx_q, cy_q, IMG_W, IMG_H);

    dog_align_fifo #(
        .DEPTH (DEPTH),
        .W     (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en_i (fifo_wr),
        .rd_en_i (fifo_rd),
        .wdata_i (a_din),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb assert (fifo_count <= CW'(DEPTH));

    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        x_d          = x_q;
        y_d          = y_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        border_d     = border_q;
        frame_end_d  = frame_end_q;
        ovf_d        = ovf_q;
        unf_d        = unf_q;
        if (clk_en) begin
            dout_valid_d = pop;
            frame_end_d  = pop & last_px;
            ovf_d        = ovf_q | (push & fifo_full & ~fifo_rd);
            unf_d        = unf_q | (b_valid & fifo_empty & ~push);
            if (pop) begin
`ifdef DOG_BORDER_MASK_EN
                dout_d = border_now ? '0 : diff;
`else
                dout_d = diff;
`endif
                x_d      = cx_q;
                y_d      = cy_q;
                border_d = border_now;
                if (cx_q == coord_t'(IMG_W - 1)) begin
                    cx_d = '0;
                    cy_d = (cy_q == coord_t'(IMG_H - 1)) ? '0 : cy_q + coord_t'(1);
                end else begin
                    cx_d = cx_q + coord_t'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            border_q     <= 1'b0;
            frame_end_q  <= 1'b0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            x_q          <= x_d;
            y_q          <= y_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            border_q     <= border_d;
            frame_end_q  <= frame_end_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign x          = x_q;
    assign y          = y_q;
    assign border     = border_q;
    assign frame_end  = frame_end_q;
    assign ovf        = ovf_q;
    assign unf        = unf_q;

endmodule

// File: tb/tb_dog_stage.sv
// Scoreboard bench for dog_stage: a queue-based reference model predicts each
// output pixel; a separate monitor compares whatever the DUT presents.
module tb_dog_stage;

    localparam int W = 20;
    localparam int H = 10;
    localparam int D = 16;

    logic       clk = 1'b0;
    logic       rst, clk_en, a_valid, b_valid;
    logic [7:0] a_din, b_din;
    logic [8:0] dout, x, y;
    logic       dout_valid, border, frame_end, ovf, unf;

    dog_stage #(.IMG_W(W), .IMG_H(H), .DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .a_din      (a_din),
        .a_valid    (a_valid),
        .b_din      (b_din),
        .b_valid    (b_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .x          (x),
        .y          (y),
        .border     (border),
        .frame_end  (frame_end),
        .ovf        (ovf),
        .unf        (unf)
    );

    always #5 clk = ~clk;

    typedef struct { int d; int x; int y; int b; int fe; int due; } exp_t;

    exp_t eq[$];
    int   mq[$];
    int   n_tests = 0, n_fail = 0;
    int   cyc = 0, pidx = 0, fe_seen = 0, n_issued = 0;
    bit   m_ovf = 0, m_unf = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: a plain queue of pending a-samples and a linear pixel index.
    task automatic drive(input bit r, input bit en, input bit av, input int ad,
                         input bit bv, input int bd);
        int   aval;
        bit   have;
        exp_t e;
        @(negedge clk);
        rst = r; clk_en = en; a_valid = av; a_din = 8'(ad); b_valid = bv; b_din = 8'(bd);
        have = 0;
        aval = 0;
        if (r) begin
            mq.delete();
            m_ovf = 0; m_unf = 0; pidx = 0;
        end else if (en) begin
            if (bv) begin
                if (mq.size() > 0) begin
                    aval = mq.pop_front(); have = 1;
                    if (av) mq.push_back(ad);
                end else if (av) begin
                    aval = ad; have = 1;
                end else begin
                    m_unf = 1;
                end
            end else if (av) begin
                if (mq.size() == D) m_ovf = 1;
                else mq.push_back(ad);
            end
        end
        if (have) begin
            e.x   = pidx % W;
            e.y   = pidx / W;
            e.b   = (e.x < 2 || e.x > W - 3 || e.y < 2 || e.y > H - 3) ? 1 : 0;
            e.fe  = (pidx == W * H - 1) ? 1 : 0;
            e.d   = (bd - aval) & 9'h1FF;
`ifdef DOG_BORDER_MASK_EN
            if (e.b == 1) e.d = 0;
`endif
            e.due = cyc + 1;
            eq.push_back(e);
            pidx = (pidx + 1) % (W * H);
            n_issued++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 1, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        drive(1, $urandom_range(0, 1), 1, 7, 1, 9);
        drive(1, 1, 0, 0, 0, 0);
    endtask

    task automatic check_flags(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_ovf"}, int'(ovf), int'(m_ovf));
        check({tag, "_unf"}, int'(unf), int'(m_unf));
    endtask

    // Monitor: one new output per enabled edge where dout_valid is presented.
    bit   en_s;
    exp_t me;
    always begin
        @(posedge clk);
        en_s = clk_en & ~rst;
        #1;
        if (en_s && dout_valid === 1'b1) begin
            if (frame_end === 1'b1) fe_seen++;
            if (eq.size() == 0) begin
                check("unexpected_dout_valid", 1, 0);
            end else begin
                me = eq.pop_front();
                check("dout",      int'(dout),      me.d);
                check("x",         int'(x),         me.x);
                check("y",         int'(y),         me.y);
                check("border",    int'(border),    me.b);
                check("frame_end", int'(frame_end), me.fe);
                check("latency",   cyc,             me.due);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fe0, bval;
        rst = 1; clk_en = 0; a_valid = 0; b_valid = 0; a_din = 0; b_din = 0;
        do_reset();
        @(posedge clk);
        #1;
        check("rst_dout", int'(dout), 0);
        check("rst_dout_valid", int'(dout_valid), 0);
        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        check("rst_border", int'(border), 0);
        check("rst_frame_end", int'(frame_end), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_unf", int'(unf), 0);

        // a=10 three cycles ahead of b=200
        drive(0, 1, 1, 10, 0, 0);
        idle(3);
        drive(0, 1, 0, 0, 1, 200);
        idle(2);

        // a=255, b=0 together at pixel (0,0)
        do_reset();
        drive(0, 1, 1, 255, 1, 0);
        idle(2);

        // 17 pushes into a 16-deep FIFO: 17th lost, then drain and underflow once
        do_reset();
        for (int i = 0; i < D + 1; i++) drive(0, 1, 1, i + 1, 0, 0);
        check_flags("fill17");
        for (int i = 0; i < D; i++) drive(0, 1, 0, 0, 1, 200);
        drive(0, 1, 0, 0, 1, 50);
        idle(2);
        check_flags("drain");

        // underflow from a clean state
        do_reset();
        drive(0, 1, 0, 0, 1, 123);
        idle(2);
        check_flags("unf");

        // reset with 5 buffered samples discards them
        do_reset();
        for (int i = 0; i < 5; i++) drive(0, 1, 1, 100 + i, 0, 0);
        do_reset();
        check_flags("rst_mid");
        drive(0, 1, 1, 40, 1, 90);
        drive(0, 1, 0, 0, 1, 77);
        idle(2);
        check_flags("post_rst");

        // full frame with random stalls, then a few wrap pixels
        do_reset();
        fe0 = fe_seen;
        n_issued = 0;
        while (n_issued < W * H + 3)
            drive(0, ($urandom_range(0, 5) != 0), 1, $urandom_range(0, 255), 1, $urandom_range(0, 255));
        idle(2);
        check("frame_end_count", fe_seen - fe0, 1);
        check_flags("frame");

        // random traffic with stalls, skew, overflow and underflow
        do_reset();
        for (int i = 0; i < 800; i++) begin
            bval = (i % 200 < 100) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
            drive(0, ($urandom_range(0, 7) != 0), $urandom_range(0, 1), $urandom_range(0, 255),
                  bval[0], $urandom_range(0, 255));
            if (i % 200 == 199) check_flags("rand");
        end
        for (int i = 0; i < D + 2; i++) drive(0, 1, 0, 0, 1, $urandom_range(0, 255));
        idle(3);
        check("scoreboard_drained", eq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
